core_sequencer: RTL

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_pkg.sv | 38 +++
 rtl/opcode_classify.sv | 43 ++++
 rtl/core_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core sequencer: FSM states, opcodes,
// PC-source encodings and the control-flow class produced by the decoder.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  typedef enum logic [1:0] {
    FLOW_SEQ,
    FLOW_BRANCH,
    FLOW_JAL,
    FLOW_JALR
  } flow_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: legality, memory direction, rd write and
// control-flow class of the current instruction.
module opcode_classify
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic       is_system,
  output logic       is_load,
  output logic       is_store,
  output logic       writes_rd,
  output flow_t      flow
);

  always_comb begin
    legal     = 1'b1;
    is_system = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    flow      = FLOW_SEQ;
    case (opcode)
      OP_OP, OP_OP32, OP_IMM, OP_IMM32, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      OP_LOAD: begin
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE:  is_store = 1'b1;
      OP_BRANCH: flow = FLOW_BRANCH;
      OP_JAL: begin
        writes_rd = 1'b1;
        flow      = FLOW_JAL;
      end
      OP_JALR: begin
        writes_rd = 1'b1;
        flow      = FLOW_JALR;
      end
      OP_SYSTEM: is_system = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with the
// retired-instruction counter; strobes are decoded from state and ready inputs.
module core_sequencer
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      state;
  logic        load_q, store_q, rd_q, taken_q;
  flow_t       flow_q;
  logic        halted_q, illegal_q;
  logic [31:0] instret_q;

  logic  dec_legal, dec_system, dec_load, dec_store, dec_rd;
  flow_t dec_flow;

  opcode_classify u_classify (
    .opcode    (opcode),
    .legal     (dec_legal),
    .is_system (dec_system),
    .is_load   (dec_load),
    .is_store  (dec_store),
    .writes_rd (dec_rd),
    .flow      (dec_flow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      rd_q      <= 1'b0;
      taken_q   <= 1'b0;
      flow_q    <= FLOW_SEQ;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (pc_we) instret_q <= instret_q + 32'd1;
      case (state)
        ST_FETCH: if (imem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          if (!dec_legal || dec_system) begin
            state     <= ST_HALT;
            halted_q  <= 1'b1;
            illegal_q <= !dec_legal;
          end else begin
            load_q  <= dec_load;
            store_q <= dec_store;
            rd_q    <= dec_rd;
            flow_q  <= dec_flow;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          taken_q <= branch_taken;
          state   <= (load_q || store_q) ? ST_MEM : ST_WB;
        end
        ST_MEM:  if (dmem_ready) state <= store_q ? ST_FETCH : ST_WB;
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
        pc_we    = store_q && dmem_ready;
      end
      ST_WB: begin
        rf_we = rd_q;
        pc_we = 1'b1;
        case (flow_q)
          FLOW_JAL:    pc_sel = PC_BRANCH;
          FLOW_BRANCH: pc_sel = taken_q ? PC_BRANCH : PC_PLUS4;
          FLOW_JALR:   pc_sel = PC_JALR;
          default:     pc_sel = PC_PLUS4;
        endcase
      end
      default: ;
    endcase
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
